// File: rtl/sequence_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : sequence_detect_param
// Description : Serial sequence detector. It compares a serial bit stream
//               against a runtime-loadable pattern with a per-bit
//               don't-care mask. It supports overlapping or non-overlapping
//               detection, emits a one-cycle detection pulse and keeps a
//               saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_detect_param #(
    parameter int                   SEQ_WIDTH = 8,
    parameter int                   CNT_WIDTH = 16,
    parameter logic [SEQ_WIDTH-1:0] PAT_INIT  = 8'b1001_0110
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 enable,
    input  logic                 data_valid,
    input  logic                 data,
    input  logic                 pattern_load,
    input  logic [SEQ_WIDTH-1:0] pattern_in,
    input  logic [SEQ_WIDTH-1:0] mask_in,
    input  logic                 overlap,
    input  logic                 count_clr,
    output logic                 detected,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 armed
);

    localparam int                   FILL_W    = $clog2(SEQ_WIDTH + 1);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(SEQ_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    state_t                 state_q,    state_d;
    logic [SEQ_WIDTH-1:0]   window_q,   window_d;
    logic [FILL_W-1:0]      fill_q,     fill_d;
    logic [SEQ_WIDTH-1:0]   pattern_q,  pattern_d;
    logic [SEQ_WIDTH-1:0]   mask_q,     mask_d;
    logic [CNT_WIDTH-1:0]   count_q,    count_d;
    logic                   detected_q, detected_d;
    logic                   armed_q,    armed_d;

    // Window after accepting the current bit, the saturated fill, and the hit flag
    logic [SEQ_WIDTH-1:0]   window_n;
    logic [FILL_W-1:0]      fill_n;
    logic                   hit;

    // State register; asynchronous active-low reset drops any partial window
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            window_q   <= '0;
            fill_q     <= '0;
            pattern_q  <= PAT_INIT;
            mask_q     <= '1;
            count_q    <= '0;
            detected_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            detected_q <= detected_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state: window shifting, hit evaluation, pattern load, counter update
    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        fill_d     = fill_q;
        pattern_d  = pattern_q;
        mask_d     = mask_q;
        count_d    = count_q;
        detected_d = 1'b0;
        hit        = 1'b0;

        // The newest bit enters at the MSB so the oldest bit sits at [0]
        window_n = {data, window_q[SEQ_WIDTH-1:1]};
        fill_n   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

        // A load is captured even while disabled
        if (pattern_load) begin
            pattern_d = pattern_in;
            mask_d    = mask_in;
        end

        if (!enable) begin
            // The bit on the disabling cycle is discarded
            state_d  = IDLE;
            window_d = '0;
            fill_d   = '0;
        end else if (pattern_load) begin
            // A partial window never mixes with a new pattern
            state_d  = FILL;
            window_d = '0;
            fill_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = FILL;
        end else if (data_valid) begin
            hit = (fill_n == FILL_FULL) &&
                  (((window_n ^ pattern_q) & mask_q) == '0);
            if (hit && !overlap) begin
                // The next detection needs a completely fresh window
                state_d  = FILL;
                window_d = '0;
                fill_d   = '0;
            end else begin
                window_d = window_n;
                fill_d   = fill_n;
                state_d  = (fill_n == FILL_FULL) ? HUNT : FILL;
            end
        end

        if (hit) begin
            detected_d = 1'b1;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end

        // The clear wins over a coincident hit
        if (count_clr) begin
            count_d = '0;
        end

        armed_d = (state_d == HUNT);
    end

    assign detected    = detected_q;
    assign match_count = count_q;
    assign armed       = armed_q;

endmodule
`default_nettype wire

// File: doc/sequence_detect_param.md
# sequence_detect_param

Parameterised serial sequence detector, successor to the fixed 4-bit, non-overlapping sync-code detector. It compares a serial bit stream against a runtime-loadable pattern of up to SEQ_WIDTH bits, with a per-bit don't-care mask, and supports overlapping or non-overlapping detection. It emits a one-cycle detection pulse and keeps a saturating match counter. It sits between the serial receive front end and frame-sync logic.

## Interface
- SEQ_WIDTH, 8: pattern/window length in bits, 2..32
- CNT_WIDTH, 16: match counter width
- PAT_INIT, 8'b1001_0110: pattern after reset (SEQ_WIDTH bits)

- clk  input  1  system clock
- Reset  input  1  asynchronous, active-low reset
- enable  input  1  1 = detector running; 0 = IDLE, window flushed
- data_valid  input  1  qualifies data for one cycle
- data  input  1  serial bit; first received bit is compared against pattern[0]
- pattern_load  input  1  one-cycle strobe; captures pattern_in and mask_in
- pattern_in  input  SEQ_WIDTH  new pattern
- mask_in  input  SEQ_WIDTH  1 = bit compared, 0 = don't care
- overlap  input  1  1 = overlapping detection, 0 = window restarts after a hit
- count_clr  input  1  synchronous clear of match_count
- detected  output  1  one-cycle pulse per match
- match_count  output  CNT_WIDTH  saturating number of matches
- armed  output  1  window full; a compare is made on every valid bit

## Operation
- Registers:
  - window[SEQ_WIDTH-1:0]
  - fill counter 0..SEQ_WIDTH
  - pattern_r and mask_r
  - state
- States:
  - IDLE: enable=0. Window and fill are 0. Compares are suppressed.
  - FILL: fill < SEQ_WIDTH.
  - HUNT: fill == SEQ_WIDTH.
- Transitions:
  - IDLE→FILL when enable=1.
  - Any state→IDLE when enable=0.
  - FILL→HUNT when a valid bit makes fill reach SEQ_WIDTH.
  - HUNT→FILL on a hit when overlap=0.
  - Any state→FILL on pattern_load while enable=1.
- Shift on each data_valid in FILL or HUNT:
  - window_n = {data, window[SEQ_WIDTH-1:1]}, so the oldest bit is window_n[0].
  - fill increments, saturating at SEQ_WIDTH.
- Hit condition: fill_n == SEQ_WIDTH and ((window_n ^ pattern_r) & mask_r) == 0, evaluated on a data_valid cycle.
- On a hit:
  - detected=1 the next cycle.
  - match_count increments, saturating at all-ones.
  - If overlap=0, fill and window clear to 0, so the next detection needs SEQ_WIDTH fresh bits.
- mask_r all-zero: every valid bit in HUNT is a hit.
- pattern_load:
  - pattern_r←pattern_in and mask_r←mask_in.
  - Window and fill flush.
  - Any data bit on the same cycle is discarded.
  - Load is accepted in IDLE too.
- count_clr: match_count←0. If a hit occurs the same cycle, the clear wins and the count is 0.
- data_valid=0: no state change. detected is 0 on the following cycle.
- overlap is sampled on each hit. Changing it mid-stream is legal.

## Timing
- Reset values:
  - detected=0, match_count=0, armed=0
  - state=IDLE, window=0, fill=0
  - pattern_r=PAT_INIT, mask_r=all ones
- Reset is asynchronous at any point, including mid-pattern. Partial window contents are lost.
- Latency: data_valid cycle of the final pattern bit at edge N → detected high for the cycle after edge N, low after edge N+1, unless the next bit also hits.
- Back-to-back hits (overlap=1, periodic pattern) give detected high on consecutive cycles.
- armed is registered. It rises the cycle after fill reaches SEQ_WIDTH.
- match_count updates in the same cycle detected rises.
- enable falling: takes effect at the next edge. A bit on that cycle is discarded and no hit is reported.
- Maximum throughput: one bit per clock.

## Test plan
- Overlapping hits: SEQ_WIDTH=4, load pattern 4'b1001 with mask 4'b1111, overlap=1, stream 1,0,0,1,0,0,1 (one bit per cycle) → detected pulses one cycle after bits 4 and 7; match_count=2.
- Non-overlapping: same stream with overlap=0 → a single pulse after bit 4; match_count=1; armed drops after the hit.
- Mask: pattern 4'b1001, mask 4'b0110, streams 0,0,0,0 and 1,0,0,1 → both detect, 2 pulses. Stream 1,1,0,1 → no detection.
- Gaps and load: insert data_valid=0 gaps between bits of 1001 → the pulse is still exactly 1 cycle after the last valid bit. Assert pattern_load mid-pattern → the partial pattern is discarded and the next hit requires 4 new bits.
- Counter: CNT_WIDTH=2, drive 5 hits → count saturates at 3. Assert count_clr on the same cycle as a hit → count=0.
- Reset and enable: drop Reset after 3 matching bits → all outputs 0 and pattern_r=PAT_INIT. Drop enable mid-stream → IDLE, no pulse; on re-enable, hits need SEQ_WIDTH new bits.
